// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: register address width,
// hazard sequencer state encoding and counter widths.
package mips_pkg;

    localparam int NB_REG_ADDR  = 5;
    localparam int NB_STALL_CNT = 32;
    localparam int NB_SEQ_CNT   = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LSTALL  = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } hcu_state_e;

endpackage

// File: rtl/hazard_compare.sv
// Combinational source-operand vs destination match; register $0 never
// produces a hazard because it is hardwired to zero.
module hazard_compare
    import mips_pkg::*;
#(
    parameter int NB_REG_ADDR = mips_pkg::NB_REG_ADDR
) (
    input  logic [NB_REG_ADDR-1:0] i_rs,
    input  logic [NB_REG_ADDR-1:0] i_rt,
    input  logic                   i_use_rs,
    input  logic                   i_use_rt,
    input  logic [NB_REG_ADDR-1:0] i_rd,
    output logic                   o_match
);

    assign o_match = (i_rd != '0) &
                     ((i_use_rs & (i_rs == i_rd)) | (i_use_rt & (i_rt == i_rd)));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, memory-wait
// freeze and HALT drain. Define HAZARD_STATS_EN to build the stall counter.
module hazard_control_unit
    import mips_pkg::*;
#(
    parameter int NB_REG_ADDR  = mips_pkg::NB_REG_ADDR,
    parameter int LOAD_LATENCY = 1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_REG_ADDR-1:0]  i_rs_id,
    input  logic [NB_REG_ADDR-1:0]  i_rt_id,
    input  logic                    i_use_rs,
    input  logic                    i_use_rt,
    input  logic                    i_mem_read_ex,
    input  logic [NB_REG_ADDR-1:0]  i_rd_ex,
    input  logic                    i_branch_taken,
    input  logic                    i_mem_busy,
    input  logic                    i_halt_id,
    output logic                    o_stall_pc,
    output logic                    o_stall_ifid,
    output logic                    o_bubble_idex,
    output logic                    o_flush_ifid,
    output logic                    o_flush_idex,
    output logic                    o_freeze,
    output logic                    o_halted,
    output logic [NB_STALL_CNT-1:0] o_stall_count
);

    localparam logic [NB_SEQ_CNT-1:0] LOAD_CNT_INIT  = NB_SEQ_CNT'(LOAD_LATENCY - 1);
    localparam logic [NB_SEQ_CNT-1:0] DRAIN_CNT_INIT = NB_SEQ_CNT'(DRAIN_CYCLES - 1);
    localparam logic [NB_SEQ_CNT-1:0] CNT_ONE        = NB_SEQ_CNT'(1);

    hcu_state_e             state_q, state_d;
    logic [NB_SEQ_CNT-1:0]  cnt_q, cnt_d;
    logic [NB_REG_ADDR-1:0] rd_load_q, rd_load_d;

    logic match_ex;
    logic match_load;

    logic stall_pc, stall_ifid, bubble_idex;
    logic flush_ifid, flush_idex, freeze, halted;

    hazard_compare #(.NB_REG_ADDR(NB_REG_ADDR)) u_cmp_ex (
        .i_rs     (i_rs_id),
        .i_rt     (i_rt_id),
        .i_use_rs (i_use_rs),
        .i_use_rt (i_use_rt),
        .i_rd     (i_rd_ex),
        .o_match  (match_ex)
    );

    hazard_compare #(.NB_REG_ADDR(NB_REG_ADDR)) u_cmp_load (
        .i_rs     (i_rs_id),
        .i_rt     (i_rt_id),
        .i_use_rs (i_use_rs),
        .i_use_rt (i_use_rt),
        .i_rd     (rd_load_q),
        .o_match  (match_load)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            rd_load_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_load_q <= rd_load_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_load_d   = rd_load_q;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        freeze      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            RUN: begin
                if (i_mem_busy) begin
                    freeze = 1'b1;
                end else if (i_branch_taken) begin
                    // Consumer in ID is squashed, so any load-use match is moot.
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (i_mem_read_ex && match_ex) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        rd_load_d = i_rd_ex;
                        cnt_d     = LOAD_CNT_INIT;
                        state_d   = LSTALL;
                    end
                end else if (i_halt_id) begin
                    stall_pc = 1'b1;
                    cnt_d    = DRAIN_CNT_INIT;
                    state_d  = DRAIN;
                end
            end
            LSTALL: begin
                if (i_mem_busy) begin
                    freeze = 1'b1;
                end else if (i_branch_taken) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    cnt_d      = '0;
                    state_d    = RUN;
                end else if (match_load) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    cnt_d       = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (i_mem_busy) begin
                    freeze = 1'b1;
                end else begin
                    // Keep clearing IF/ID so nothing fetched after HALT reaches ID.
                    stall_pc   = 1'b1;
                    flush_ifid = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            HALTED: begin
                halted   = 1'b1;
                stall_pc = 1'b1;
                freeze   = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign o_stall_pc    = stall_pc    & ~i_reset;
    assign o_stall_ifid  = stall_ifid  & ~i_reset;
    assign o_bubble_idex = bubble_idex & ~i_reset;
    assign o_flush_ifid  = flush_ifid  & ~i_reset;
    assign o_flush_idex  = flush_idex  & ~i_reset;
    assign o_freeze      = freeze      & ~i_reset;
    assign o_halted      = halted      & ~i_reset;

`ifdef HAZARD_STATS_EN
    logic [NB_STALL_CNT-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_pc || freeze) && (state_q != HALTED) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + NB_STALL_CNT'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_count = i_reset ? '0 : stall_cnt_q;
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized and directed bench for hazard_control_unit, checked against a
// cycle-level behavioural model of the hazard rules.
module tb_hazard_control_unit;

    localparam int LL = 3;
    localparam int DC = 3;

    logic       clk;
    logic       rst;
    logic [4:0] rs_id, rt_id, rd_ex;
    logic       use_rs, use_rt, mem_read_ex, branch_taken, mem_busy, halt_id;
    logic       stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, freeze, halted;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Model state: remaining stall cycles, remaining drain cycles, halted flag.
    int          m_stall_left = 0;
    int          m_stall_rd   = 0;
    int          m_drain_left = 0;
    bit          m_halted     = 0;
    logic [31:0] m_cnt        = 0;

    hazard_control_unit #(
        .NB_REG_ADDR  (5),
        .LOAD_LATENCY (LL),
        .DRAIN_CYCLES (DC)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_rs_id        (rs_id),
        .i_rt_id        (rt_id),
        .i_use_rs       (use_rs),
        .i_use_rt       (use_rt),
        .i_mem_read_ex  (mem_read_ex),
        .i_rd_ex        (rd_ex),
        .i_branch_taken (branch_taken),
        .i_mem_busy     (mem_busy),
        .i_halt_id      (halt_id),
        .o_stall_pc     (stall_pc),
        .o_stall_ifid   (stall_ifid),
        .o_bubble_idex  (bubble_idex),
        .o_flush_ifid   (flush_ifid),
        .o_flush_idex   (flush_idex),
        .o_freeze       (freeze),
        .o_halted       (halted),
        .o_stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit uses(input int rs, input int rt, input bit urs, input bit urt, input int rd);
        return (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input logic r, input logic busy, input logic br, input logic hlt,
                         input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt);
        logic [6:0]  e;   // {stall_pc, stall_ifid, bubble, flush_ifid, flush_idex, freeze, halted}
        logic [31:0] ecnt;
        bit          was_halted;
        @(negedge clk);
        rst = r; mem_busy = busy; branch_taken = br; halt_id = hlt;
        mem_read_ex = mr; rd_ex = rd; rs_id = rs; rt_id = rt; use_rs = urs; use_rt = urt;
        #1;
        e = '0;
        ecnt = m_cnt;
        was_halted = m_halted;
        if (r) begin
            ecnt = 0;
            m_stall_left = 0; m_drain_left = 0; m_halted = 0; m_cnt = 0;
        end else begin
            if (m_halted) begin
                e = 7'b1000011;
            end else if (busy) begin
                e = 7'b0000010;
            end else if (m_drain_left > 0) begin
                e = 7'b1001000;
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (br) begin
                e = 7'b0001100;
                m_stall_left = 0;
            end else if (m_stall_left > 0) begin
                if (uses(rs, rt, urs, urt, m_stall_rd)) begin
                    e = 7'b1110000;
                    m_stall_left--;
                end else begin
                    m_stall_left = 0;
                end
            end else if (mr && uses(rs, rt, urs, urt, rd)) begin
                e = 7'b1110000;
                m_stall_left = LL - 1;
                m_stall_rd   = rd;
            end else if (hlt) begin
                e = 7'b1000000;
                m_drain_left = DC;
            end
            if (!was_halted && (e[6] || e[1]) && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
`ifndef HAZARD_STATS_EN
        ecnt = 0;
`endif
        check("outputs", {25'b0, stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, freeze, halted},
              {25'b0, e});
        check("stall_count", stall_count, ecnt);
    endtask

    task automatic idle(input logic r);
        cycle(r, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        rst = 1; mem_busy = 0; branch_taken = 0; halt_id = 0; mem_read_ex = 0;
        rd_ex = 0; rs_id = 0; rt_id = 0; use_rs = 0; use_rt = 0;

        idle(1);
        idle(1);
        idle(0);

        // Load rd=5, ID reads rs=5; then rd=0 must not stall.
        cycle(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0);
        cycle(0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd1, 1, 0);
        cycle(0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd1, 1, 0);
        cycle(0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd1, 1, 0);
        idle(0);
        cycle(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);

        // Load rd=7 used by rt, with memory wait on the second stall cycle.
        cycle(0, 0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 1, 1);
        cycle(0, 1, 0, 0, 0, 5'd0, 5'd2, 5'd7, 1, 1);
        cycle(0, 0, 0, 0, 0, 5'd0, 5'd2, 5'd7, 1, 1);
        cycle(0, 0, 0, 0, 0, 5'd0, 5'd2, 5'd7, 1, 1);
        cycle(0, 0, 0, 0, 0, 5'd0, 5'd2, 5'd7, 1, 1);

        // Hazard together with a taken branch: flush wins.
        cycle(0, 0, 1, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        idle(0);

        // Reset mid-stall, then a fresh hazard gets the full count.
        cycle(0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0);
        cycle(1, 0, 0, 0, 0, 5'd0, 5'd4, 5'd0, 1, 0);
        cycle(0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 5'd0, 5'd4, 5'd0, 1, 0);

        // Stall statistics: two full load stalls plus three freeze cycles.
        idle(1);
        for (int k = 0; k < 2; k++) begin
            cycle(0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
            for (int i = 0; i < LL - 1; i++) cycle(0, 0, 0, 0, 0, 5'd0, 5'd3, 5'd0, 1, 0);
            idle(0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(0);
`ifdef HAZARD_STATS_EN
        check("stats_total", stall_count, 32'd9);
`else
        check("stats_total", stall_count, 32'd0);
`endif

        // HALT drain, then busy is ignored once halted.
        cycle(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < DC; i++) idle(0);
        cycle(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("halted_seen", {31'b0, halted}, 32'd1);
        idle(0);
        idle(1);

        // Randomized traffic over a small register space to provoke matches.
        for (int n = 0; n < 4000; n++) begin
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
